// File: rtl/test_completion_monitor.sv
// test_completion_monitor: sequences DUT reset, then latches a sticky PASS/FAIL verdict from per-channel
// success/failure, a runtime cycle timeout and a per-channel heartbeat watchdog.
module test_completion_monitor #(
  parameter int N_CHAN = 4,
  parameter int CYCLE_W = 64,
  parameter int RESET_CYCLES = 16,
  parameter int HANG_LIMIT = 0,
  parameter int REQUIRE_ALL = 1,
  localparam int CHAN_W = N_CHAN > 1 ? $clog2(N_CHAN) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CYCLE_W-1:0]  max_cycles,
  input  logic [N_CHAN-1:0]   chan_success,
  input  logic [N_CHAN-1:0]   chan_failure,
  input  logic [N_CHAN-1:0]   chan_heartbeat,
  output logic                dut_reset,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic [1:0]          fail_reason,
  output logic [CHAN_W-1:0]   fail_chan,
  output logic [N_CHAN-1:0]   success_mask,
  output logic [CYCLE_W-1:0]  cycle_count
);
  localparam int RC_W = $clog2(RESET_CYCLES + 1);
  localparam int IDLE_W = HANG_LIMIT > 0 ? $clog2(HANG_LIMIT + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(HANG_LIMIT > 0 ? HANG_LIMIT - 1 : 0);
  typedef enum logic [1:0] {S_RESET, S_RUN, S_PASS, S_FAIL} state_t;
  state_t state, state_next;
  logic [RC_W-1:0] rst_cnt;
  logic [IDLE_W-1:0] idle [N_CHAN];
  logic [N_CHAN-1:0] mask_next, expire;
  logic [CHAN_W-1:0] fail_idx, hang_idx, chan_next;
  logic [1:0] reason_next;
  logic complete, timeout;
  always_comb begin
    mask_next = success_mask | chan_success;
    complete = REQUIRE_ALL != 0 ? &mask_next : |mask_next;
    timeout = max_cycles != '0 && {1'b0, cycle_count} + (CYCLE_W+1)'(1) >= {1'b0, max_cycles};
    expire = '0;
    fail_idx = '0;
    hang_idx = '0;
    // descending scan so the lowest set index wins
    for (int i = N_CHAN - 1; i >= 0; i--) begin
      expire[i] = HANG_LIMIT > 0 && !chan_heartbeat[i] && !success_mask[i] && idle[i] == IDLE_LAST;
      fail_idx = chan_failure[i] ? CHAN_W'(i) : fail_idx;
      hang_idx = expire[i] ? CHAN_W'(i) : hang_idx;
    end
    state_next = state;
    reason_next = fail_reason;
    chan_next = fail_chan;
    if (state == S_RESET)
      state_next = rst_cnt == RC_W'(RESET_CYCLES - 1) ? S_RUN : S_RESET;
    else if (state == S_RUN) begin
      if (|chan_failure) begin
        state_next = S_FAIL;
        reason_next = 2'd1;
        chan_next = fail_idx;
      end else if (complete)
        state_next = S_PASS;
      else if (timeout) begin
        state_next = S_FAIL;
        reason_next = 2'd2;
      end else if (|expire) begin
        state_next = S_FAIL;
        reason_next = 2'd3;
        chan_next = hang_idx;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_RESET;
      rst_cnt <= '0;
      dut_reset <= 1'b1;
      done <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
      fail_reason <= '0;
      fail_chan <= '0;
      success_mask <= '0;
      cycle_count <= '0;
    end else begin
      state <= state_next;
      rst_cnt <= state == S_RESET ? rst_cnt + RC_W'(1) : rst_cnt;
      dut_reset <= state_next == S_RESET;
      done <= state_next == S_PASS || state_next == S_FAIL;
      pass <= state_next == S_PASS;
      fail <= state_next == S_FAIL;
      fail_reason <= reason_next;
      fail_chan <= chan_next;
      if (state == S_RUN) begin
        success_mask <= mask_next;
        cycle_count <= &cycle_count ? cycle_count : cycle_count + CYCLE_W'(1);
      end
    end
  end
  // idle counters only advance in RUN; a succeeded channel is exempt from the watchdog
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_CHAN; i++) begin
      if (reset || state == S_RESET)
        idle[i] <= '0;
      else if (state == S_RUN)
        idle[i] <= (HANG_LIMIT == 0 || chan_heartbeat[i] || success_mask[i]) ? '0 : idle[i] + IDLE_W'(1);
    end
  end
  assert property (@(posedge clock) !(pass && fail));
  assert property (@(posedge clock) done == (pass || fail));
endmodule

// File: tb/tb_test_completion_monitor.sv
// tb_test_completion_monitor: three monitor configurations driven in lockstep, each compared every cycle
// against a timestamp-based behavioural model, plus directed end-of-scenario checks.
module tb_test_completion_monitor;
  logic clock = 1'b0, reset = 1'b1;
  logic [63:0] max_a = '0, max_c = '0;
  logic [3:0] max_b = '0;
  logic [3:0] succ = '0, failv = '0, hb = '1;
  logic [2:0] o_dr, o_done, o_pass, o_fail;
  logic [2:0][1:0] o_reason, o_chan;
  logic [2:0][3:0] o_mask;
  logic [2:0][63:0] o_cnt;
  logic [3:0] cnt_b;
  int n_checks = 0, n_fail = 0;
  // model: configuration and per-instance verdict state
  string names [3] = '{"all", "any", "hang"};
  int p_req [3] = '{1, 0, 1};
  int p_hang [3] = '{0, 0, 8};
  longint unsigned p_cmax [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd15, 64'hFFFF_FFFF_FFFF_FFFF};
  int since_rst = 0;
  bit m_done [3], m_pass [3];
  int m_reason [3], m_chan [3];
  logic [3:0] m_mask [3];
  longint unsigned m_cnt [3];
  int last_beat [3][4];

  always #5 clock = ~clock;
  assign o_cnt[1] = {60'd0, cnt_b};

  test_completion_monitor #(.N_CHAN(4), .CYCLE_W(64), .RESET_CYCLES(16), .HANG_LIMIT(0), .REQUIRE_ALL(1)) u_all (
    .clock(clock), .reset(reset), .max_cycles(max_a), .chan_success(succ), .chan_failure(failv),
    .chan_heartbeat(hb), .dut_reset(o_dr[0]), .done(o_done[0]), .pass(o_pass[0]), .fail(o_fail[0]),
    .fail_reason(o_reason[0]), .fail_chan(o_chan[0]), .success_mask(o_mask[0]), .cycle_count(o_cnt[0]));
  test_completion_monitor #(.N_CHAN(4), .CYCLE_W(4), .RESET_CYCLES(16), .HANG_LIMIT(0), .REQUIRE_ALL(0)) u_any (
    .clock(clock), .reset(reset), .max_cycles(max_b), .chan_success(succ), .chan_failure(failv),
    .chan_heartbeat(hb), .dut_reset(o_dr[1]), .done(o_done[1]), .pass(o_pass[1]), .fail(o_fail[1]),
    .fail_reason(o_reason[1]), .fail_chan(o_chan[1]), .success_mask(o_mask[1]), .cycle_count(cnt_b));
  test_completion_monitor #(.N_CHAN(4), .CYCLE_W(64), .RESET_CYCLES(16), .HANG_LIMIT(8), .REQUIRE_ALL(1)) u_hang (
    .clock(clock), .reset(reset), .max_cycles(max_c), .chan_success(succ), .chan_failure(failv),
    .chan_heartbeat(hb), .dut_reset(o_dr[2]), .done(o_done[2]), .pass(o_pass[2]), .fail(o_fail[2]),
    .fail_reason(o_reason[2]), .fail_chan(o_chan[2]), .success_mask(o_mask[2]), .cycle_count(o_cnt[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned max_of(input int k);
    return k == 0 ? max_a : k == 1 ? longint'(max_b) : max_c;
  endfunction

  task automatic model_step();
    int t, hang_ch, low;
    logic [3:0] nm;
    longint unsigned mx;
    if (reset) begin
      since_rst = 0;
      for (int k = 0; k < 3; k++) begin
        m_done[k] = 0; m_pass[k] = 0; m_reason[k] = 0; m_chan[k] = 0; m_mask[k] = '0; m_cnt[k] = 0;
        for (int i = 0; i < 4; i++) last_beat[k][i] = -1;
      end
    end else if (since_rst < 16)
      since_rst++;
    else begin
      t = since_rst - 16;
      since_rst++;
      for (int k = 0; k < 3; k++) if (!m_done[k]) begin
        nm = m_mask[k] | succ;
        mx = max_of(k);
        hang_ch = -1;
        low = -1;
        for (int i = 3; i >= 0; i--) begin
          if (failv[i]) low = i;
          if (p_hang[k] > 0 && !hb[i] && !m_mask[k][i] && t - last_beat[k][i] >= p_hang[k]) hang_ch = i;
        end
        if (low >= 0) begin
          m_done[k] = 1; m_reason[k] = 1; m_chan[k] = low;
        end else if (p_req[k] != 0 ? nm == 4'hF : nm != 4'h0) begin
          m_done[k] = 1; m_pass[k] = 1;
        end else if (mx != 0 && m_cnt[k] >= mx - 1) begin
          m_done[k] = 1; m_reason[k] = 2;
        end else if (hang_ch >= 0) begin
          m_done[k] = 1; m_reason[k] = 3; m_chan[k] = hang_ch;
        end
        m_cnt[k] = m_cnt[k] == p_cmax[k] ? m_cnt[k] : m_cnt[k] + 1;
        m_mask[k] = nm;
        for (int i = 0; i < 4; i++) if (hb[i]) last_beat[k][i] = t;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      check({names[k], ".dut_reset"}, o_dr[k], since_rst < 16);
      check({names[k], ".done"}, o_done[k], m_done[k]);
      check({names[k], ".pass"}, o_pass[k], m_pass[k]);
      check({names[k], ".fail"}, o_fail[k], m_done[k] && !m_pass[k]);
      check({names[k], ".reason"}, o_reason[k], m_reason[k]);
      check({names[k], ".chan"}, o_chan[k], m_chan[k]);
      check({names[k], ".mask"}, o_mask[k], m_mask[k]);
      check({names[k], ".count"}, o_cnt[k], m_cnt[k]);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_all();
  endtask

  task automatic quiet();
    succ = '0; failv = '0; hb = '1;
  endtask

  task automatic start_run();
    quiet();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (16) tick();
  endtask

  task automatic run_t1();
    for (int t = 0; t <= 45; t++) begin
      succ = (t % 10 == 0 && t >= 10 && t <= 40) ? 4'(1 << (t / 10 - 1)) : 4'h0;
      tick();
    end
    check("t1.all.pass", o_pass[0], 1);
    check("t1.all.count", o_cnt[0], 41);
    check("t1.all.mask", o_mask[0], 4'hF);
    check("t1.any.mask", o_mask[1], 4'b0001);
    check("t1.any.count", o_cnt[1], 11);
    check("t1.hang.pass", o_pass[2], 1);
  endtask

  initial begin
    quiet();
    repeat (3) tick();
    check("rst.dut_reset", o_dr[0], 1);
    check("rst.done", o_done[0], 0);
    reset = 1'b0;
    for (int c = 0; c < 16; c++) begin
      check("rst.hold", o_dr[0], 1);
      tick();
    end
    check("rst.release", o_dr[0], 0);
    run_t1();
    // T2: any-success configuration on a lone channel 2
    start_run();
    for (int t = 0; t <= 8; t++) begin
      succ = t == 5 ? 4'b0100 : 4'h0;
      tick();
    end
    check("t2.any.pass", o_pass[1], 1);
    check("t2.any.mask", o_mask[1], 4'b0100);
    check("t2.all.done", o_done[0], 0);
    // T3: timeouts, including max_cycles at the saturation value
    max_a = 64'd100; max_b = 4'hF;
    start_run();
    repeat (110) tick();
    check("t3.all.reason", o_reason[0], 2);
    check("t3.all.count", o_cnt[0], 100);
    check("t3.any.reason", o_reason[1], 2);
    check("t3.any.count", o_cnt[1], 15);
    check("t3.hang.done", o_done[2], 0);
    // T6: one-cycle reset out of FAIL, garbage inputs during reset sequencing, then a clean pass
    reset = 1'b1;
    tick();
    check("t6.done", o_done[0], 0);
    check("t6.dut_reset", o_dr[0], 1);
    check("t6.count", o_cnt[0], 0);
    check("t6.reason", o_reason[0], 0);
    reset = 1'b0;
    max_a = '0; max_b = '0;
    succ = '1; failv = '1; hb = '0;
    repeat (16) tick();
    quiet();
    run_t1();
    // T4: failure outranks a same-cycle completion
    start_run();
    for (int t = 0; t <= 8; t++) begin
      succ = t == 5 ? 4'hF : 4'h0;
      failv = t == 5 ? 4'b1010 : 4'h0;
      tick();
    end
    check("t4.all.reason", o_reason[0], 1);
    check("t4.all.chan", o_chan[0], 1);
    check("t4.hang.fail", o_fail[2], 1);
    // T5: channel 3 stops beating after cycle 19
    start_run();
    for (int t = 0; t <= 34; t++) begin
      hb = t >= 20 ? 4'b0111 : 4'hF;
      tick();
    end
    check("t5.hang.reason", o_reason[2], 3);
    check("t5.hang.chan", o_chan[2], 3);
    check("t5.hang.count", o_cnt[2], 28);
    // T5b: a silent channel that already succeeded never hangs
    start_run();
    for (int t = 0; t <= 30; t++) begin
      hb = 4'b0111;
      succ = t == 2 ? 4'b1000 : 4'h0;
      tick();
    end
    check("t5b.hang.done", o_done[2], 0);
    // long run without timeout: no verdict, narrow counter saturates
    start_run();
    repeat (10000) tick();
    check("long.all.done", o_done[0], 0);
    check("long.any.count", o_cnt[1], 15);
    // randomized runs
    for (int r = 0; r < 25; r++) begin
      logic [3:0] dead;
      max_a = 64'($urandom_range(200));
      max_b = 4'($urandom);
      max_c = 64'($urandom_range(200));
      dead = 4'($urandom);
      start_run();
      for (int c = 0; c < 200; c++) begin
        for (int i = 0; i < 4; i++) begin
          succ[i] = $urandom_range(59) == 0;
          failv[i] = $urandom_range(399) == 0;
          hb[i] = dead[i] ? $urandom_range(15) == 0 : $urandom_range(7) != 0;
        end
        reset = $urandom_range(499) == 0;
        tick();
      end
      reset = 1'b0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
